// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions for the receiver and transmitter
//
// Contents:
//   uart_state_t         : serial frame state machine encoding (IDLE..BREAK)
//   DATA_BITS            : payload bits per frame (8N1 framing)
//   CLKS_PER_BIT_DEFAULT : default clk cycles per serial bit

package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for one asynchronous input bit
//
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset; both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronized output (two clk cycles of latency)

module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with a one-entry output register
//
// Ports:
//   clk       : system clock, all state on the rising edge
//   rst_n     : asynchronous active-low reset (deassertion synchronized upstream)
//   rx        : asynchronous serial line, idle high, LSB first
//   data      : received byte, valid while rx_valid=1
//   rx_valid  : output register holds a byte
//   rx_ready  : consumer takes the byte when rx_valid & rx_ready
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, completed byte dropped because output was occupied
//   busy      : receiver is not in IDLE

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  // Counter terminal values; the counter reloads to 0 on every sample so it
  // never needs to count past CLKS_PER_BIT-1.
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_t          state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;

  // Reset value 1 so a reset never looks like a start edge.
  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // Consumer handshake; a byte completing in the same cycle overrides
      // this below and keeps rx_valid high with the new byte.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state   <= START;
            bit_idx <= '0;
            busy    <= 1'b1;
          end
        end

        // Re-check the line at the middle of the start bit to reject glitches.
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Samples land mid-bit because START already consumed half a bit.
        DATA: begin
          if (cnt == FULL_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == FULL_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
              if (!rx_valid || rx_ready) begin
                data     <= shreg;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Line held low (break or framing fault): wait for idle before
        // arming start detection again.
        BREAK: begin
          cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx

module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int fe_cnt = 0;
  int ov_cnt = 0;
  int vld_hi = 0;
  int hs_cnt = 0;
  int rise_cnt = 0;
  int rise_cyc = 0;
  logic [7:0] hs_data = 8'h00;
  logic vld_prev = 1'b0;

  uart_rx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .data     (data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (overrun) ov_cnt = ov_cnt + 1;
    if (rx_valid) vld_hi = vld_hi + 1;
    if (rx_valid && rx_ready) begin
      hs_cnt  = hs_cnt + 1;
      hs_data = data;
    end
    if (rx_valid && !vld_prev) begin
      rise_cnt = rise_cnt + 1;
      rise_cyc = cyc;
    end
    vld_prev = rx_valid;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_bits(input logic [7:0] b, input logic stop, input int stop_cycles);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    rx = stop;
    repeat (stop_cycles) tick();
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_bits(b, 1'b1, CPB);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_basic();
    int b_hs, b_fe, b_ov, b_vld, b_rise, t0, lat;
    rx_ready = 1'b1;
    b_hs = hs_cnt; b_fe = fe_cnt; b_ov = ov_cnt; b_vld = vld_hi; b_rise = rise_cnt;
    t0 = cyc;
    send_frame(8'hA5);
    repeat (8) tick();
    lat = rise_cyc - t0;
    checks++; if (hs_cnt - b_hs !== 1) begin errors++; $display("FAIL basic_accepts: got %0d expected 1", hs_cnt - b_hs); end
    checks++; if (hs_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", hs_data); end
    checks++; if (vld_hi - b_vld !== 1) begin errors++; $display("FAIL basic_valid_cycles: got %0d expected 1", vld_hi - b_vld); end
    checks++; if (rise_cnt - b_rise !== 1) begin errors++; $display("FAIL basic_valid_rises: got %0d expected 1", rise_cnt - b_rise); end
    checks++; if (lat < 154 || lat > 156) begin errors++; $display("FAIL basic_latency: got %0d expected 155 +-1", lat); end
    checks++; if (fe_cnt - b_fe !== 0) begin errors++; $display("FAIL basic_frame_err: got %0d expected 0", fe_cnt - b_fe); end
    checks++; if (ov_cnt - b_ov !== 0) begin errors++; $display("FAIL basic_overrun: got %0d expected 0", ov_cnt - b_ov); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_glitch();
    int b_rise, b_fe;
    b_rise = rise_cnt; b_fe = fe_cnt;
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (30) tick();
    checks++; if (rise_cnt - b_rise !== 0) begin errors++; $display("FAIL glitch_valid: got %0d expected 0", rise_cnt - b_rise); end
    checks++; if (fe_cnt - b_fe !== 0) begin errors++; $display("FAIL glitch_frame_err: got %0d expected 0", fe_cnt - b_fe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b expected 0", busy); end
  endtask

  task automatic test_frame_error();
    int b_rise, b_fe;
    rx_ready = 1'b1;
    b_rise = rise_cnt; b_fe = fe_cnt;
    send_bits(8'h3C, 1'b0, 40);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_in_break: got %b expected 1", busy); end
    checks++; if (fe_cnt - b_fe !== 1) begin errors++; $display("FAIL ferr_pulses: got %0d expected 1", fe_cnt - b_fe); end
    checks++; if (rise_cnt - b_rise !== 0) begin errors++; $display("FAIL ferr_valid: got %0d expected 0", rise_cnt - b_rise); end
    rx = 1'b1;
    repeat (5) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_after: got %b expected 0", busy); end
    repeat (20) tick();
  endtask

  task automatic test_overrun();
    int b_hs, b_fe, b_ov;
    rx_ready = 1'b0;
    b_hs = hs_cnt; b_fe = fe_cnt; b_ov = ov_cnt;
    send_frame(8'h11);
    send_frame(8'h22);
    repeat (8) tick();
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %b expected 1", rx_valid); end
    checks++; if (data !== 8'h11) begin errors++; $display("FAIL ovr_data_held: got %h expected 11", data); end
    checks++; if (ov_cnt - b_ov !== 1) begin errors++; $display("FAIL ovr_pulses: got %0d expected 1", ov_cnt - b_ov); end
    checks++; if (fe_cnt - b_fe !== 0) begin errors++; $display("FAIL ovr_frame_err: got %0d expected 0", fe_cnt - b_fe); end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_drop: got %b expected 0", rx_valid); end
    checks++; if (hs_cnt - b_hs !== 1) begin errors++; $display("FAIL ovr_accepts: got %0d expected 1", hs_cnt - b_hs); end
    checks++; if (hs_data !== 8'h11) begin errors++; $display("FAIL ovr_consumed: got %h expected 11", hs_data); end
    repeat (5) tick();
  endtask

  task automatic test_ready_at_completion();
    int b_hs, b_ov;
    rx_ready = 1'b0;
    send_frame(8'h11);
    repeat (4) tick();
    checks++; if (data !== 8'h11 || rx_valid !== 1'b1) begin errors++; $display("FAIL rac_held: got %h/%b expected 11/1", data, rx_valid); end
    b_hs = hs_cnt; b_ov = ov_cnt;
    fork
      send_frame(8'h22);
      begin
        repeat (154) tick();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
      end
    join
    repeat (4) tick();
    checks++; if (ov_cnt - b_ov !== 0) begin errors++; $display("FAIL rac_overrun: got %0d expected 0", ov_cnt - b_ov); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL rac_valid: got %b expected 1", rx_valid); end
    checks++; if (data !== 8'h22) begin errors++; $display("FAIL rac_data: got %h expected 22", data); end
    checks++; if (hs_cnt - b_hs !== 1) begin errors++; $display("FAIL rac_accepts: got %0d expected 1", hs_cnt - b_hs); end
    checks++; if (hs_data !== 8'h11) begin errors++; $display("FAIL rac_consumed: got %h expected 11", hs_data); end
  endtask

  task automatic test_reset_mid_frame();
    int b_rise, b_hs, b_fe;
    rx_ready = 1'b0;
    b_rise = rise_cnt;
    fork
      send_frame(8'hFF);
      begin
        repeat (CPB + 4 * CPB + CPB / 2) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL rmf_data: got %h expected 00", data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rmf_valid: got %b expected 0", rx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmf_busy: got %b expected 0", busy); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rmf_flags: got %b%b expected 00", frame_err, overrun); end
        rst_n = 1'b1;
      end
    join
    repeat (10) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmf_busy_after: got %b expected 0", busy); end
    checks++; if (rise_cnt - b_rise !== 0) begin errors++; $display("FAIL rmf_no_byte: got %0d expected 0", rise_cnt - b_rise); end
    rx_ready = 1'b1;
    b_hs = hs_cnt; b_fe = fe_cnt;
    send_frame(8'h5A);
    repeat (8) tick();
    checks++; if (hs_cnt - b_hs !== 1) begin errors++; $display("FAIL rmf_next_accepts: got %0d expected 1", hs_cnt - b_hs); end
    checks++; if (hs_data !== 8'h5A) begin errors++; $display("FAIL rmf_next_data: got %h expected 5a", hs_data); end
    checks++; if (fe_cnt - b_fe !== 0) begin errors++; $display("FAIL rmf_next_frame_err: got %0d expected 0", fe_cnt - b_fe); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_ready_at_completion();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
